// File: rtl/bp_me_stream_arbiter.sv
// bp_me_stream_arbiter: round-robin arbiter merging BP stream requesters onto one output,
// holding the grant for the whole of a locked burst.
module bp_me_stream_arbiter #(
  parameter int num_requesters_p = 2,
  parameter int header_width_p   = 64,
  parameter int data_width_p     = 64
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [num_requesters_p*header_width_p-1:0] header_i,
  input  logic [num_requesters_p*data_width_p-1:0]   data_i,
  input  logic [num_requesters_p-1:0]                v_i,
  input  logic [num_requesters_p-1:0]                lock_i,
  output logic [num_requesters_p-1:0]                yumi_o,
  output logic [header_width_p-1:0]                  header_o,
  output logic [data_width_p-1:0]                    data_o,
  output logic                                       v_o,
  input  logic                                       yumi_i,
  output logic                                       lock_o,
  output logic [((num_requesters_p > 1) ? $clog2(num_requesters_p) : 1)-1:0] grant_id_o
);
  localparam int id_w_lp = (num_requesters_p > 1) ? $clog2(num_requesters_p) : 1;
  typedef enum logic {e_idle, e_locked} state_e;
  state_e state_r, state_n;
  logic [id_w_lp-1:0] owner_r, owner_n, last_r, last_n, rr_sel, sel, j;
  logic found, locked;
  int idx;
  always_comb begin
    rr_sel = last_r;
    found  = 1'b0;
    idx    = 0;
    j      = '0;
    for (int i = 1; i <= num_requesters_p; i++) begin
      idx = int'(last_r) + i;
      idx = (idx >= num_requesters_p) ? idx - num_requesters_p : idx;
      j   = id_w_lp'(idx);
      if (!found && v_i[j]) begin
        rr_sel = j;
        found  = 1'b1;
      end
    end
  end
  // Reset masks the outputs so nothing is offered while ownership is being torn down.
  always_comb begin
    locked     = (state_r == e_locked);
    sel        = locked ? owner_r : rr_sel;
    v_o        = !reset_i && (locked ? (lock_i[owner_r] && v_i[owner_r]) : found);
    lock_o     = !reset_i && (locked ? lock_i[owner_r] : (lock_i[sel] && v_i[sel]));
    yumi_o     = {{(num_requesters_p-1){1'b0}}, v_o && yumi_i} << sel;
    header_o   = header_i[sel*header_width_p +: header_width_p];
    data_o     = data_i[sel*data_width_p +: data_width_p];
    grant_id_o = sel;
    state_n    = state_r;
    owner_n    = owner_r;
    last_n     = last_r;
    if (locked) begin
      state_n = lock_i[owner_r] ? e_locked : e_idle;
    end else if (v_o && yumi_i) begin
      last_n  = sel;
      owner_n = lock_i[sel] ? sel : owner_r;
      state_n = lock_i[sel] ? e_locked : e_idle;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      owner_r <= '0;
      last_r  <= id_w_lp'(num_requesters_p - 1);
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
    end
  end
endmodule
